win_checker: RTL



---
 rtl/win_checker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/win_checker.sv
// Five-in-a-row detector for the N x N game board.
// A start in IDLE snapshots the board, then one (cell, direction) pair is
// examined per cycle in the fixed order p = 4*idx + dir. The first line of
// WIN_LEN equal player stones ends the scan; otherwise the scan runs to the end
// and reports a draw when no empty cell remains. Results hold until the next
// accepted start.
module win_checker #(
    parameter int N       = 6,
    parameter int WIN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] board [N*N-1:0],
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       draw,
    output logic [5:0] win_cell,
    output logic [1:0] win_dir
);

    localparam int         CELLS  = N * N;
    localparam int         NPAIR  = 4 * CELLS;
    localparam logic [7:0] LAST_P = 8'(NPAIR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [1:0] r_snap [CELLS-1:0];
    logic [7:0] r_p;
    logic [1:0] r_winner;
    logic       r_draw;
    logic [5:0] r_win_cell;
    logic [1:0] r_win_dir;

    logic [5:0] w_idx;
    logic [1:0] w_dir;
    int         w_row;
    int         w_col;
    int         w_dr;
    int         w_dc;
    logic       w_fit;
    logic [1:0] w_colour;
    logic       w_same;
    logic       w_hit;
    logic [5:0] w_cell_k;
    logic       w_any_empty;
    logic       w_scan_end;

    assign w_idx      = r_p[7:2];
    assign w_dir      = r_p[1:0];
    assign w_scan_end = (r_p == LAST_P);

    // Evaluate the current (cell, direction) pair against the snapshot.
    always_comb begin
        w_row    = int'(w_idx) / N;
        w_col    = int'(w_idx) % N;
        w_dr     = 0;
        w_dc     = 1;
        w_fit    = 1'b0;
        w_colour = 2'b00;
        w_same   = 1'b0;
        w_hit    = 1'b0;
        w_cell_k = 6'd0;
        case (w_dir)
            2'd0: begin
                w_dr  = 0;
                w_dc  = 1;
                w_fit = (w_col <= N - WIN_LEN);
            end
            2'd1: begin
                w_dr  = 1;
                w_dc  = 0;
                w_fit = (w_row <= N - WIN_LEN);
            end
            2'd2: begin
                w_dr  = 1;
                w_dc  = 1;
                w_fit = (w_col <= N - WIN_LEN) && (w_row <= N - WIN_LEN);
            end
            default: begin
                w_dr  = 1;
                w_dc  = -1;
                w_fit = (w_col >= WIN_LEN - 1) && (w_row <= N - WIN_LEN);
            end
        endcase
        // The counter value CELLS*4 is the trailing no-hit cycle, not a real pair.
        if (w_fit && (r_p < LAST_P)) begin
            w_colour = r_snap[w_idx];
            w_same   = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                w_cell_k = 6'((w_row + k * w_dr) * N + w_col + k * w_dc);
                if (r_snap[w_cell_k] != w_colour) begin
                    w_same = 1'b0;
                end
            end
            w_hit = w_same && ((w_colour == 2'b01) || (w_colour == 2'b10));
        end
    end

    // Any cell reading 00 or 11 counts as empty for the draw decision.
    always_comb begin
        w_any_empty = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if ((r_snap[i] == 2'b00) || (r_snap[i] == 2'b11)) begin
                w_any_empty = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_hit || w_scan_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Board snapshot taken on an accepted start; later board changes are ignored.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && start) begin
            r_snap <= board;
        end
    end

    // Pair counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p        <= 8'd0;
            r_winner   <= 2'b00;
            r_draw     <= 1'b0;
            r_win_cell <= 6'd0;
            r_win_dir  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p        <= 8'd0;
                        r_winner   <= 2'b00;
                        r_draw     <= 1'b0;
                        r_win_cell <= 6'd0;
                        r_win_dir  <= 2'd0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_winner   <= w_colour;
                        r_win_cell <= w_idx;
                        r_win_dir  <= w_dir;
                    end else if (w_scan_end) begin
                        r_winner <= 2'b00;
                        r_draw   <= ~w_any_empty;
                    end else begin
                        r_p <= r_p + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign winner   = r_winner;
    assign draw     = r_draw;
    assign win_cell = r_win_cell;
    assign win_dir  = r_win_dir;

endmodule
